bp_update_queue: RTL and testbench

- Write-side companion to the branch predictor: collects resolved branches from execute, detects mispredictions, and drains updates in order into the predictor's write port (wr_en/wr_taken/wr_target/wr_pc/wr_bhr).
- Owns the speculative global branch history register (spec_bhr) that fetch feeds to the predictor read side.
- On a misprediction, repairs spec_bhr and emits a one-cycle redirect to fetch.

---
 rtl/bp_update_queue_pkg.sv | 28 ++
 rtl/bp_update_queue_if.sv | 39 +++
 rtl/bp_update_queue_fifo.sv | 47 ++++
 rtl/bp_update_queue.sv | 86 ++++++++
 tb/tb_bp_update_queue.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/bp_update_queue_pkg.sv
// Shared types for the branch-predictor update queue: the queued entry and sizing defaults.
// Optional same-cycle bypass of an empty queue is enabled by defining BP_UPDATE_BYPASS_EN.
`ifndef BRANCH_HISTORY_REG_SZ
`define BRANCH_HISTORY_REG_SZ 4
`endif
`ifndef BP_UPDATE_QUEUE_DEPTH
`define BP_UPDATE_QUEUE_DEPTH 8
`endif

package bp_update_queue_pkg;
  localparam int ADDR_W = 32;
  localparam int BHR_W  = `BRANCH_HISTORY_REG_SZ;
  localparam int QDEPTH = `BP_UPDATE_QUEUE_DEPTH;

  typedef logic [ADDR_W-1:0] ADDR;

  typedef struct packed {
    ADDR              pc;
    ADDR              target;
    logic             taken;
    logic [BHR_W-1:0] bhr;
  } BP_UPDATE_ENTRY;

  // A target mismatch only matters when the branch was actually taken.
  function automatic logic is_mispredict(logic taken, logic pred_taken, ADDR target, ADDR pred_target);
    return (taken != pred_taken) || (taken && (target != pred_target));
  endfunction
endpackage

// File: rtl/bp_update_queue_if.sv
// Bundle between execute/fetch/predictor and the update queue; slave is the queue side.
interface bp_update_queue_if import bp_update_queue_pkg::*; #(
  parameter int BHR_DEPTH   = BHR_W,
  parameter int QUEUE_DEPTH = QDEPTH
) ();
  logic                         pred_valid;
  logic                         pred_taken;
  logic                         res_valid;
  logic                         res_ready;
  ADDR                          res_pc;
  logic                         res_taken;
  ADDR                          res_target;
  logic                         res_pred_taken;
  ADDR                          res_pred_target;
  logic [BHR_DEPTH-1:0]         res_bhr;
  logic                         wr_en;
  logic                         wr_taken;
  ADDR                          wr_target;
  ADDR                          wr_pc;
  logic [BHR_DEPTH-1:0]         wr_bhr;
  logic [BHR_DEPTH-1:0]         spec_bhr;
  logic                         mispredict;
  ADDR                          redirect_pc;
  logic [$clog2(QUEUE_DEPTH):0] count;

  modport slave (
    input  pred_valid, pred_taken, res_valid, res_pc, res_taken, res_target,
           res_pred_taken, res_pred_target, res_bhr,
    output res_ready, wr_en, wr_taken, wr_target, wr_pc, wr_bhr, spec_bhr,
           mispredict, redirect_pc, count
  );

  modport master (
    output pred_valid, pred_taken, res_valid, res_pc, res_taken, res_target,
           res_pred_taken, res_pred_target, res_bhr,
    input  res_ready, wr_en, wr_taken, wr_target, wr_pc, wr_bhr, spec_bhr,
           mispredict, redirect_pc, count
  );
endinterface

// File: rtl/bp_update_queue_fifo.sv
// Circular FIFO of predictor update entries; DEPTH must be a power of two so pointers wrap naturally.
module bp_update_fifo import bp_update_queue_pkg::*; #(
  parameter int DEPTH = QDEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  BP_UPDATE_ENTRY           din_i,
  input  logic                     pop_i,
  output BP_UPDATE_ENTRY           dout_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  BP_UPDATE_ENTRY mem_q [DEPTH];
  logic [PW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CW'(push_i) - CW'(pop_i);
    if (push_i) tail_d = tail_q + 1'b1;
    if (pop_i)  head_d = head_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[tail_q] <= din_i;
  end

  assign dout_o  = mem_q[head_q];
  assign count_o = count_q;
endmodule

// File: rtl/bp_update_queue.sv
// Orders resolved branches into the predictor write port, owns speculative history, flags mispredicts.
// Define BP_UPDATE_BYPASS_EN to let an accept into an empty queue reach the write port the same cycle.
module bp_update_queue import bp_update_queue_pkg::*; #(
  parameter int BHR_DEPTH   = BHR_W,
  parameter int QUEUE_DEPTH = QDEPTH
) (
  input  logic             clock,
  input  logic             reset,
  bp_update_queue_if.slave bus
);
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  logic                 ready, accept, mis, push, pop, bypass;
  BP_UPDATE_ENTRY       res_ent, head_ent, wr_ent;
  logic [CW-1:0]        fifo_count;
  logic [BHR_DEPTH-1:0] spec_bhr_q, spec_bhr_d;
  logic                 mis_q, mis_d;
  ADDR                  redirect_q, redirect_d;

  assign ready   = fifo_count < CW'(QUEUE_DEPTH);
  assign accept  = bus.res_valid && ready;
  assign mis     = is_mispredict(bus.res_taken, bus.res_pred_taken, bus.res_target, bus.res_pred_target);
  assign res_ent = '{pc: bus.res_pc, target: bus.res_target, taken: bus.res_taken, bhr: bus.res_bhr};

`ifdef BP_UPDATE_BYPASS_EN
  assign bypass = accept && (fifo_count == '0);
`else
  assign bypass = 1'b0;
`endif

  // The predictor never back-pressures, so any occupied head is consumed this cycle.
  assign pop  = fifo_count != '0;
  assign push = accept && !bypass;

  bp_update_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
    .clk     (clock),
    .rst     (reset),
    .push_i  (push),
    .din_i   (res_ent),
    .pop_i   (pop),
    .dout_o  (head_ent),
    .count_o (fifo_count)
  );

  always_comb begin
    wr_ent = head_ent;
    if (bypass) wr_ent = res_ent;
  end

  // A mispredict rebuilds history from the branch's own snapshot; same-cycle fetch is wrong-path.
  always_comb begin
    spec_bhr_d = spec_bhr_q;
    mis_d      = 1'b0;
    redirect_d = redirect_q;
    if (accept && mis) begin
      spec_bhr_d = {bus.res_bhr[BHR_DEPTH-2:0], bus.res_taken};
      mis_d      = 1'b1;
      redirect_d = bus.res_taken ? bus.res_target : bus.res_pc + ADDR'(4);
    end else if (bus.pred_valid) begin
      spec_bhr_d = {spec_bhr_q[BHR_DEPTH-2:0], bus.pred_taken};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      spec_bhr_q <= '0;
      mis_q      <= 1'b0;
      redirect_q <= '0;
    end else begin
      spec_bhr_q <= spec_bhr_d;
      mis_q      <= mis_d;
      redirect_q <= redirect_d;
    end
  end

  assign bus.res_ready   = ready;
  assign bus.wr_en       = pop || bypass;
  assign bus.wr_pc       = wr_ent.pc;
  assign bus.wr_target   = wr_ent.target;
  assign bus.wr_taken    = wr_ent.taken;
  assign bus.wr_bhr      = wr_ent.bhr;
  assign bus.spec_bhr    = spec_bhr_q;
  assign bus.mispredict  = mis_q;
  assign bus.redirect_pc = redirect_q;
  assign bus.count       = fifo_count;
endmodule

// File: tb/tb_bp_update_queue.sv
// Scoreboard bench for bp_update_queue: directed results, a monitor checks write port and redirects.
module tb_bp_update_queue;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  bp_update_queue_if #(.BHR_DEPTH(4), .QUEUE_DEPTH(8)) bus ();

  bp_update_queue #(.BHR_DEPTH(4), .QUEUE_DEPTH(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
    logic [3:0]  bhr;
  } exp_t;

  typedef struct {
    int          due;
    logic [31:0] rpc;
  } mis_t;

  exp_t sb[$];
  mis_t mq[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   stall = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Holds a result until accepted; expectations are queued on the cycle it is seen ready.
  task automatic send(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                      input logic ptk, input logic [31:0] ptgt, input logic [3:0] bhr);
    bit done = 0;
    bus.res_valid = 1'b1;
    bus.res_pc = pc;  bus.res_target = tgt;  bus.res_taken = tk;
    bus.res_pred_taken = ptk;  bus.res_pred_target = ptgt;  bus.res_bhr = bhr;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clock);
      if (bus.res_ready) begin
        sb.push_back('{pc, tgt, tk, bhr});
        if ((tk != ptk) || (tk && (tgt != ptgt)))
          mq.push_back('{cyc + 1, tk ? tgt : pc + 32'd4});
        done = 1;
      end
      @(posedge clock);
      #1;
    end
    if (!done) chk("send_timeout", {63'd0, bus.res_ready}, 64'd1);
    bus.res_valid = 1'b0;
  endtask

  // Monitor: the predictor consumes whatever wr_en presents unless the tb is modelling a stall.
  initial begin
    exp_t e;
    mis_t m;
    forever begin
      @(negedge clock);
      #1;
      if (!reset) begin
        if (bus.wr_en && !(stall && bus.count != 0)) begin
          if (sb.size() == 0) chk("wr_unexpected", {63'd0, bus.wr_en}, 64'd0);
          else begin
            e = sb.pop_front();
            chk("wr_pc", {32'd0, bus.wr_pc}, {32'd0, e.pc});
            chk("wr_target", {32'd0, bus.wr_target}, {32'd0, e.target});
            chk("wr_taken", {63'd0, bus.wr_taken}, {63'd0, e.taken});
            chk("wr_bhr", {60'd0, bus.wr_bhr}, {60'd0, e.bhr});
          end
        end
        if (mq.size() != 0 && mq[0].due == cyc) begin
          m = mq.pop_front();
          chk("mispredict_pulse", {63'd0, bus.mispredict}, 64'd1);
          chk("redirect_pc", {32'd0, bus.redirect_pc}, {32'd0, m.rpc});
        end else begin
          chk("mispredict_idle", {63'd0, bus.mispredict}, 64'd0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.pred_valid = 0;  bus.pred_taken = 0;  bus.res_valid = 0;
    bus.res_pc = 0;  bus.res_taken = 0;  bus.res_target = 0;
    bus.res_pred_taken = 0;  bus.res_pred_target = 0;  bus.res_bhr = 0;

    // Reset state and idle
    #1;
    chk("rst_wr_en", {63'd0, bus.wr_en}, 64'd0);
    chk("rst_count", {60'd0, bus.count}, 64'd0);
    chk("rst_spec_bhr", {60'd0, bus.spec_bhr}, 64'd0);
    chk("rst_redirect", {32'd0, bus.redirect_pc}, 64'd0);
    repeat (3) step();
    reset = 1'b0;
    repeat (5) step();
    chk("idle_wr_en", {63'd0, bus.wr_en}, 64'd0);
    chk("idle_count", {60'd0, bus.count}, 64'd0);
    chk("idle_spec_bhr", {60'd0, bus.spec_bhr}, 64'd0);
    chk("idle_mispredict", {63'd0, bus.mispredict}, 64'd0);
    chk("idle_ready", {63'd0, bus.res_ready}, 64'd1);

    // Speculative history shifts in fetch predictions
    bus.pred_valid = 1;  bus.pred_taken = 1;  step();
    chk("bhr_0001", {60'd0, bus.spec_bhr}, 64'h1);
    bus.pred_taken = 0;  step();
    chk("bhr_0010", {60'd0, bus.spec_bhr}, 64'h2);
    bus.pred_taken = 1;  step();
    chk("bhr_0101", {60'd0, bus.spec_bhr}, 64'h5);
    bus.pred_valid = 0;

    // Correct prediction: one-cycle enqueue latency (zero with bypass)
    send(32'h100, 32'h200, 1, 1, 32'h200, 4'h0);
`ifdef BP_UPDATE_BYPASS_EN
    chk("t3_wr_en", {63'd0, bus.wr_en}, 64'd0);
`else
    chk("t3_wr_en", {63'd0, bus.wr_en}, 64'd1);
    chk("t3_wr_pc", {32'd0, bus.wr_pc}, 64'h100);
    chk("t3_wr_target", {32'd0, bus.wr_target}, 64'h200);
`endif
    chk("t3_no_mis", {63'd0, bus.mispredict}, 64'd0);
    chk("t3_bhr_hold", {60'd0, bus.spec_bhr}, 64'h5);
    step();

    // Not-taken mispredict with a same-cycle fetch prediction that must be dropped
    bus.pred_valid = 1;  bus.pred_taken = 1;
    send(32'h40, 32'h0, 0, 1, 32'h300, 4'b0110);
    bus.pred_valid = 0;
    chk("t4_mis", {63'd0, bus.mispredict}, 64'd1);
    chk("t4_redirect", {32'd0, bus.redirect_pc}, 64'h44);
    chk("t4_bhr", {60'd0, bus.spec_bhr}, 64'hC);
    step();
    chk("t4_mis_clear", {63'd0, bus.mispredict}, 64'd0);
    chk("t4_redirect_hold", {32'd0, bus.redirect_pc}, 64'h44);
    repeat (2) step();

    // Empty-queue accept: bypass build presents it combinationally
    bus.res_valid = 1;  bus.res_pc = 32'h80;  bus.res_target = 32'h90;
    bus.res_taken = 0;  bus.res_pred_taken = 0;  bus.res_pred_target = 32'h90;  bus.res_bhr = 4'h3;
    #1;
`ifdef BP_UPDATE_BYPASS_EN
    chk("byp_wr_en", {63'd0, bus.wr_en}, 64'd1);
    chk("byp_wr_pc", {32'd0, bus.wr_pc}, 64'h80);
`else
    chk("nobyp_wr_en", {63'd0, bus.wr_en}, 64'd0);
`endif
    send(32'h80, 32'h90, 0, 0, 32'h90, 4'h3);
`ifdef BP_UPDATE_BYPASS_EN
    chk("byp_count", {60'd0, bus.count}, 64'd0);
`else
    chk("nobyp_count", {60'd0, bus.count}, 64'd1);
`endif
    repeat (2) step();

    // Nine back-to-back results while draining, with two mispredicts mixed in
    for (int i = 0; i < 9; i++) begin
      logic [31:0] pc, tgt, ptgt;
      logic        tk, ptk;
      pc = 32'h1000 + 32'(i) * 16;  tgt = 32'h2000 + 32'(i) * 8;
      tk = (i % 2) == 1;  ptk = (i == 3) ? 1'b0 : tk;
      ptgt = (i == 5 || i == 2) ? tgt + 32'd4 : tgt;
      send(pc, tgt, tk, ptk, ptgt, 4'(i));
    end
    chk("wrap_bhr", {60'd0, bus.spec_bhr}, 64'hB);
    repeat (3) step();
    chk("wrap_count", {60'd0, bus.count}, 64'd0);

    // Predictor stalled: fill to full, the next result must wait
    force dut.pop = 1'b0;
    stall = 1;
    for (int k = 0; k < 20 && bus.count < 8; k++)
      send(32'h3000 + 32'(k) * 4, 32'h0, 0, 0, 32'h0, 4'(k));
    chk("full_count", {60'd0, bus.count}, 64'd8);
    chk("full_ready", {63'd0, bus.res_ready}, 64'd0);
    bus.res_valid = 1;  bus.res_pc = 32'h3100;  bus.res_taken = 0;
    bus.res_pred_taken = 0;  bus.res_target = 0;  bus.res_pred_target = 0;  bus.res_bhr = 4'hF;
    repeat (3) step();
    chk("held_count", {60'd0, bus.count}, 64'd8);
    release dut.pop;
    stall = 0;
    send(32'h3100, 32'h0, 0, 0, 32'h0, 4'hF);
    repeat (12) step();
    chk("drain_count", {60'd0, bus.count}, 64'd0);

    // Reset mid-operation with queued entries and a pending redirect
    force dut.pop = 1'b0;
    stall = 1;
    send(32'h5000, 32'h0, 0, 0, 32'h0, 4'h1);
    send(32'h5004, 32'h0, 0, 0, 32'h0, 4'h2);
    send(32'h5008, 32'h6000, 1, 0, 32'h0, 4'h3);
    chk("pre_rst_nonempty", {63'd0, bus.count != 0}, 64'd1);
    reset = 1'b1;
    sb.delete();
    mq.delete();
    #1;
    chk("mid_rst_wr_en", {63'd0, bus.wr_en}, 64'd0);
    chk("mid_rst_count", {60'd0, bus.count}, 64'd0);
    chk("mid_rst_mis", {63'd0, bus.mispredict}, 64'd0);
    chk("mid_rst_bhr", {60'd0, bus.spec_bhr}, 64'd0);
    release dut.pop;
    stall = 0;
    repeat (2) step();
    reset = 1'b0;
    repeat (3) step();
    chk("post_rst_wr_en", {63'd0, bus.wr_en}, 64'd0);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    chk("mq_drained", 64'(mq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
